// File: rtl/decoder_nx2n_seq_pkg.sv
// Shared constants and helpers for the registered N-to-2^N decoder.
package decoder_pkg;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_SCAN  = 2'd3;

  // Operating modes; 2'b11 is reserved and behaves as level
  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  // Bit 'pos' of the one-hot code for index 'idx'
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/decoder_nx2n_seq_onehot_dec.sv
// Combinational N -> 2^N one-hot decoder with selectable output polarity.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic [N-1:0]        addr,
  output logic [0:(2**N)-1]   dec_c
);

  localparam int unsigned W = 2 ** N;

  // dec_c[i] is active when addr == i; polarity flipped for active-low
  always_comb begin
    dec_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      dec_c[i] = onehot_bit(32'(addr), i) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N decoder with valid/ready input and level, pulse and scan modes.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned PULSE_LEN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        addr,
  output logic [0:(2**N)-1]   y,
  output logic                y_valid,
  output logic                busy,
  output logic                scan_wrap
);

  localparam int unsigned W  = 2 ** N;
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam logic [0:W-1] Y_IDLE = {W{ACTIVE_LOW}};

  logic [1:0]    state, state_nx;
  logic [N-1:0]  scan_cnt, scan_nx;
  logic [PW-1:0] pulse_cnt, pulse_nx;
  logic [0:W-1]  y_nx;
  logic          y_valid_nx, busy_nx, wrap_nx;
  logic [N-1:0]  dec_sel;
  logic [0:W-1]  dec_c;
  logic          accept;

  // Ready only in a settled state, outside scan requests and reset
  always_comb begin
    in_ready = ~rst & en & ((state == ST_IDLE) | (state == ST_HOLD)) & (mode != MODE_SCAN);
    accept   = in_valid & in_ready;
  end

  // Decoder source: next scan index while scanning, index 0 on scan entry, else addr
  always_comb begin
    dec_sel = addr;
    if (state == ST_SCAN) begin
      dec_sel = scan_cnt + N'(1);
    end else if (mode == MODE_SCAN) begin
      dec_sel = '0;
    end
  end

  onehot_dec #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .addr  (dec_sel),
    .dec_c (dec_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    y_nx     = y;
    scan_nx  = scan_cnt;
    pulse_nx = pulse_cnt;
    wrap_nx  = 1'b0;

    if (!en) begin
      state_nx = ST_IDLE;
      y_nx     = Y_IDLE;
      scan_nx  = '0;
      pulse_nx = '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (mode == MODE_SCAN) begin
            state_nx = ST_SCAN;
            scan_nx  = '0;
            y_nx     = dec_c;
          end else if (accept) begin
            y_nx = dec_c;
            case (mode)
              MODE_LEVEL: state_nx = ST_HOLD;
              MODE_PULSE: begin
                state_nx = ST_PULSE;
                pulse_nx = PW'(1);
              end
              default:    state_nx = ST_HOLD;
            endcase
          end
        end
        ST_PULSE: begin
          if (pulse_cnt >= PW'(PULSE_LEN)) begin
            state_nx = ST_IDLE;
            y_nx     = Y_IDLE;
            pulse_nx = '0;
          end else begin
            pulse_nx = pulse_cnt + PW'(1);
          end
        end
        ST_SCAN: begin
          if (mode != MODE_SCAN) begin
            state_nx = ST_IDLE;
            y_nx     = Y_IDLE;
            scan_nx  = '0;
          end else begin
            scan_nx = scan_cnt + N'(1);
            y_nx    = dec_c;
            wrap_nx = (scan_nx == '1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          y_nx     = Y_IDLE;
          scan_nx  = '0;
          pulse_nx = '0;
        end
      endcase
    end

    y_valid_nx = (state_nx != ST_IDLE);
    busy_nx    = (state_nx == ST_PULSE) | (state_nx == ST_SCAN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      y         <= Y_IDLE;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      scan_wrap <= 1'b0;
      scan_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_nx;
      y         <= y_nx;
      y_valid   <= y_valid_nx;
      busy      <= busy_nx;
      scan_wrap <= wrap_nx;
      scan_cnt  <= scan_nx;
      pulse_cnt <= pulse_nx;
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: directed vector table, N=3 sweep and randomized model check.
module tb_decoder_nx2n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, in_valid;
  logic [1:0] mode;
  logic [1:0] addr2;
  logic [2:0] addr3;
  logic       rdy2, rdy3, v2, v3, b2, b3, w2, w3;
  logic [0:3] y2;
  logic [0:7] y3;

  int checks = 0;
  int errors = 0;

  decoder_nx2n_seq #(.N(2), .ACTIVE_LOW(1'b1), .PULSE_LEN(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy2),
    .addr(addr2), .y(y2), .y_valid(v2), .busy(b2), .scan_wrap(w2)
  );

  decoder_nx2n_seq #(.N(3), .ACTIVE_LOW(1'b0), .PULSE_LEN(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy3),
    .addr(addr3), .y(y3), .y_valid(v3), .busy(b3), .scan_wrap(w3)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // ---------------- reference model (index 0: N=2/AL=1/PL=3, index 1: N=3/AL=0/PL=1)
  localparam int K_IDLE = 0, K_HOLD = 1, K_PULSE = 2, K_SCAN = 3;
  int m_kind[2];
  int m_idx[2];
  int m_left[2];
  int p_w[2]  = '{4, 8};
  int p_al[2] = '{1, 0};
  int p_pl[2] = '{3, 1};

  function automatic logic m_ready(input int k, input logic r, input logic e, input logic [1:0] md);
    return !r && e && (m_kind[k] == K_IDLE || m_kind[k] == K_HOLD) && md != 2'b10;
  endfunction

  task automatic m_step(input int k, input logic r, input logic e, input logic [1:0] md,
                        input logic iv, input int a);
    if (r || !e) begin
      m_kind[k] = K_IDLE; m_idx[k] = 0; m_left[k] = 0;
    end else begin
      case (m_kind[k])
        K_IDLE, K_HOLD: begin
          if (md == 2'b10) begin
            m_kind[k] = K_SCAN; m_idx[k] = 0;
          end else if (iv) begin
            m_idx[k] = a;
            if (md == 2'b01) begin
              m_kind[k] = K_PULSE; m_left[k] = p_pl[k] - 1;
            end else begin
              m_kind[k] = K_HOLD;
            end
          end
        end
        K_PULSE: begin
          if (m_left[k] == 0) m_kind[k] = K_IDLE;
          else m_left[k] = m_left[k] - 1;
        end
        default: begin
          if (md != 2'b10) m_kind[k] = K_IDLE;
          else m_idx[k] = (m_idx[k] + 1) % p_w[k];
        end
      endcase
    end
  endtask

  // Expected y packed with y[0] as the most significant of the W used bits
  function automatic logic [7:0] m_y(input int k);
    logic [7:0] e = '0;
    for (int i = 0; i < p_w[k]; i++) begin
      e[p_w[k] - 1 - i] = ((m_kind[k] != K_IDLE) && (i == m_idx[k])) ^ (p_al[k] != 0);
    end
    return e;
  endfunction

  function automatic logic m_valid(input int k);
    return m_kind[k] != K_IDLE;
  endfunction

  function automatic logic m_busy(input int k);
    return m_kind[k] == K_PULSE || m_kind[k] == K_SCAN;
  endfunction

  function automatic logic m_wrap(input int k);
    return m_kind[k] == K_SCAN && m_idx[k] == p_w[k] - 1;
  endfunction

  // ---------------- directed vector table (dut2)
  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic       iv;
    logic [1:0] addr;
    int         reps;
    logic       rdy;
    logic [3:0] y;
    logic       v, b, w;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, input int e, input int md, input int iv, input int a,
                     input int reps, input int rdy, input int yv, input int v, input int b,
                     input int w);
    vec_t t;
    t.rst = 1'(r); t.en = 1'(e); t.mode = 2'(md); t.iv = 1'(iv); t.addr = 2'(a);
    t.reps = reps; t.rdy = 1'(rdy); t.y = 4'(yv); t.v = 1'(v); t.b = 1'(b); t.w = 1'(w);
    tbl.push_back(t);
  endtask

  initial begin
    // reset and level
    add(1, 0, 0, 0, 0, 1, 0, 'b1111, 0, 0, 0);
    add(1, 1, 0, 1, 2, 1, 0, 'b1111, 0, 0, 0);
    add(0, 1, 0, 1, 2, 1, 1, 'b1101, 1, 0, 0);
    add(0, 1, 0, 0, 2, 10, 1, 'b1101, 1, 0, 0);
    // back-to-back level accepts
    add(0, 1, 0, 1, 0, 1, 1, 'b0111, 1, 0, 0);
    add(0, 1, 0, 1, 3, 1, 1, 'b1110, 1, 0, 0);
    add(0, 1, 0, 1, 1, 1, 1, 'b1011, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 'b1111, 0, 0, 0);
    // pulse of 3 cycles, requests and mode changes ignored meanwhile
    add(0, 1, 1, 1, 1, 1, 1, 'b1011, 1, 1, 0);
    add(0, 1, 1, 1, 2, 1, 0, 'b1011, 1, 1, 0);
    add(0, 1, 0, 1, 3, 1, 0, 'b1011, 1, 1, 0);
    add(0, 1, 1, 1, 2, 1, 0, 'b1111, 0, 0, 0);
    add(0, 1, 1, 0, 2, 1, 1, 'b1111, 0, 0, 0);
    // scan, two full turns, then leave
    add(0, 1, 2, 0, 0, 1, 0, 'b0111, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1011, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1101, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1110, 1, 1, 1);
    add(0, 1, 2, 0, 0, 1, 0, 'b0111, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1011, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1101, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1110, 1, 1, 1);
    add(0, 1, 0, 0, 0, 1, 0, 'b1111, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 'b1111, 0, 0, 0);
    // pulse aborted by en low in its second cycle, no resumption
    add(0, 1, 1, 1, 3, 1, 1, 'b1110, 1, 1, 0);
    add(0, 1, 1, 0, 3, 1, 0, 'b1110, 1, 1, 0);
    add(0, 0, 1, 1, 3, 1, 0, 'b1111, 0, 0, 0);
    add(0, 1, 1, 0, 3, 2, 1, 'b1111, 0, 0, 0);
    // reset during scan restarts the counter
    add(0, 1, 2, 0, 0, 1, 0, 'b0111, 1, 1, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b1011, 1, 1, 0);
    add(1, 1, 2, 0, 0, 1, 0, 'b1111, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1, 0, 'b0111, 1, 1, 0);
    add(0, 0, 2, 0, 0, 1, 0, 'b1111, 0, 0, 0);
    // reserved mode behaves as level
    add(0, 1, 3, 1, 2, 1, 1, 'b1101, 1, 0, 0);
    add(0, 1, 3, 0, 1, 1, 1, 'b1101, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 'b1111, 0, 0, 0);

    rst = 1'b1; en = 1'b0; mode = 2'b00; in_valid = 1'b0; addr2 = '0; addr3 = '0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode;
        in_valid = tbl[i].iv; addr2 = tbl[i].addr; addr3 = {1'b0, tbl[i].addr};
        #1;
        check($sformatf("vec%0d.%0d in_ready", i, k), 8'(rdy2), 8'(tbl[i].rdy));
        @(posedge clk); #1;
        check($sformatf("vec%0d.%0d y", i, k), 8'(y2), 8'(tbl[i].y));
        check($sformatf("vec%0d.%0d y_valid", i, k), 8'(v2), 8'(tbl[i].v));
        check($sformatf("vec%0d.%0d busy", i, k), 8'(b2), 8'(tbl[i].b));
        check($sformatf("vec%0d.%0d scan_wrap", i, k), 8'(w2), 8'(tbl[i].w));
      end
    end

    // ---------------- N=3, active-high sweep on dut3
    begin
      int wraps = 0;
      rst = 1'b1; en = 1'b1; mode = 2'b00; in_valid = 1'b0;
      @(posedge clk); #1;
      check("n3 reset y", 8'(y3), 8'b00000000);
      rst = 1'b0; in_valid = 1'b1; addr3 = 3'd5;
      @(posedge clk); #1;
      check("n3 level y", 8'(y3), 8'b00000100);
      check("n3 level y_valid", 8'(v3), 8'd1);
      in_valid = 1'b0; mode = 2'b10;
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        check($sformatf("n3 scan%0d y", k), 8'(y3), 8'(8'b10000000 >> (k % 8)));
        check($sformatf("n3 scan%0d wrap", k), 8'(w3), 8'((k % 8) == 7));
        if (w3) wraps++;
      end
      check("n3 wrap count", 8'(wraps), 8'd2);
      mode = 2'b00;
      @(posedge clk); #1;
      check("n3 scan exit y", 8'(y3), 8'b00000000);
      check("n3 scan exit busy", 8'(b3), 8'd0);
    end

    // ---------------- randomized run against the model, both instances
    rst = 1'b1; en = 1'b1; mode = 2'b00; in_valid = 1'b0;
    @(posedge clk); #1;
    m_step(0, 1'b1, 1'b1, 2'b00, 1'b0, 0);
    m_step(1, 1'b1, 1'b1, 2'b00, 1'b0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic r0, r1;
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      addr2 = 2'($urandom_range(0, 3));
      addr3 = 3'($urandom_range(0, 7));
      #1;
      r0 = m_ready(0, rst, en, mode);
      r1 = m_ready(1, rst, en, mode);
      check($sformatf("rnd%0d n2 in_ready", c), 8'(rdy2), 8'(r0));
      check($sformatf("rnd%0d n3 in_ready", c), 8'(rdy3), 8'(r1));
      @(posedge clk); #1;
      m_step(0, rst, en, mode, in_valid, int'(addr2));
      m_step(1, rst, en, mode, in_valid, int'(addr3));
      check($sformatf("rnd%0d n2 y", c), 8'(y2), m_y(0));
      check($sformatf("rnd%0d n2 y_valid", c), 8'(v2), 8'(m_valid(0)));
      check($sformatf("rnd%0d n2 busy", c), 8'(b2), 8'(m_busy(0)));
      check($sformatf("rnd%0d n2 scan_wrap", c), 8'(w2), 8'(m_wrap(0)));
      check($sformatf("rnd%0d n3 y", c), 8'(y3), m_y(1));
      check($sformatf("rnd%0d n3 y_valid", c), 8'(v3), 8'(m_valid(1)));
      check($sformatf("rnd%0d n3 busy", c), 8'(b3), 8'(m_busy(1)));
      check($sformatf("rnd%0d n3 scan_wrap", c), 8'(w3), 8'(m_wrap(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
